// File: rtl/fft_uart_pkg.sv
// Shared definitions for the FFT-result UART transmitter.
//   state_t        : FSM states. The top walks the word/frame states. The byte
//                    serialiser uses IDLE/START/DATA/STOP as its line phases.
//   START_BIT/STOP_BIT/BITS_PER_BYTE : UART 8N1 framing constants.
//   clog2()        : ceiling log2, usable in parameter and port widths.
package fft_uart_pkg;

   typedef enum logic [2:0] {
      IDLE, WAIT_RDY, FETCH, LATCH, START, DATA, STOP, NEXT
   } state_t;

   localparam logic START_BIT     = 1'b0;
   localparam logic STOP_BIT      = 1'b1;
   localparam int   BITS_PER_BYTE = 8;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/fft_uart_tx_byte.sv
// uart_byte_tx: serialises one byte as 8N1 (start, 8 data bits LSB first, stop).
//   clk, rst_n  : clock and async active-low reset
//   byte_in     : byte to send, sampled when accepted
//   byte_valid  : request; accepted while idle or in the last stop-bit cycle
//   byte_ack    : high during the last cycle of the stop bit
//   txd         : registered serial line, idle high
// Accepting a new byte in the last stop cycle lets bytes run back to back with
// no idle gap, so a byte always costs exactly 10*CLKS_PER_BIT cycles.
module uart_byte_tx
   import fft_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [BITS_PER_BYTE-1:0] byte_in,
   input  logic                     byte_valid,
   output logic                     byte_ack,
   output logic                     txd
);

   localparam int CNTW = (CLKS_PER_BIT > 1) ? clog2(CLKS_PER_BIT) : 1;
   localparam int BIW  = clog2(BITS_PER_BYTE);
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(CLKS_PER_BIT - 1);
   localparam logic [BIW-1:0]  BIT_LAST = BIW'(BITS_PER_BYTE - 1);

   state_t                   phase;
   logic [CNTW-1:0]          clk_cnt;
   logic [BIW-1:0]           bit_idx;
   logic [BITS_PER_BYTE-1:0] sr;
   logic                     bit_end;
   logic                     load;

   // The timer restarts from 0 on every bit, so edges never drift.
   assign bit_end  = (clk_cnt == CNT_LAST);
   assign byte_ack = (phase == STOP) && bit_end;
   assign load     = byte_valid && ((phase == IDLE) || byte_ack);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase   <= IDLE;
         txd     <= STOP_BIT;
         clk_cnt <= '0;
         bit_idx <= '0;
         sr      <= '0;
      end else if (load) begin
         phase   <= START;
         txd     <= START_BIT;
         sr      <= byte_in;
         clk_cnt <= '0;
         bit_idx <= '0;
      end else if (phase != IDLE) begin
         if (!bit_end) begin
            clk_cnt <= clk_cnt + CNTW'(1);
         end else begin
            clk_cnt <= '0;
            case (phase)
               START: begin
                  phase   <= DATA;
                  txd     <= sr[0];
                  sr      <= sr >> 1;
                  bit_idx <= '0;
               end
               DATA: begin
                  if (bit_idx == BIT_LAST) begin
                     phase <= STOP;
                     txd   <= STOP_BIT;
                  end else begin
                     bit_idx <= bit_idx + BIW'(1);
                     txd     <= sr[0];
                     sr      <= sr >> 1;
                  end
               end
               STOP: begin
                  phase <= IDLE;
                  txd   <= STOP_BIT;
               end
               default: begin
                  phase <= IDLE;
                  txd   <= STOP_BIT;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/fft_uart_tx.sv
// fft_uart_tx: drains FFT result words from a standard-mode FIFO and sends
// them little-endian over UART 8N1. It handshakes with the MCU per word and
// pulses tx_done_sig after each frame of FRAME_LEN words.
//   fifo_empty/fifo_dout/fifo_rd_en : FIFO read side (data valid 1 cycle after rd_en)
//   rx_ready    : MCU ready (async, 2-flop synchronised)
//   tx_ready    : frame pending or in progress
//   uart_txd    : serial line, idle high
//   tx_done_sig : 1-cycle pulse in the cycle after the frame's last stop bit
//   word_cnt    : words fully sent in the current frame
module fft_uart_tx
   import fft_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int FRAME_LEN    = 1024,
   parameter int DATA_W       = 32
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            fifo_empty,
   input  logic [DATA_W-1:0]               fifo_dout,
   output logic                            fifo_rd_en,
   input  logic                            rx_ready,
   output logic                            tx_ready,
   output logic                            uart_txd,
   output logic                            tx_done_sig,
   output logic [clog2(FRAME_LEN+1)-1:0]   word_cnt
);

   localparam int NB  = DATA_W / BITS_PER_BYTE;
   localparam int BIW = (NB > 1) ? clog2(NB) : 1;
   localparam int WCW = clog2(FRAME_LEN + 1);
   localparam logic [BIW-1:0] LAST_BYTE = BIW'(NB - 1);
   localparam logic [WCW-1:0] LAST_WORD = WCW'(FRAME_LEN - 1);

   state_t                   state;
   logic [1:0]               rdy_sync;
   logic [DATA_W-1:0]        word_sr;
   logic [BIW-1:0]           byte_idx;
   logic [BITS_PER_BYTE-1:0] byte_in;
   logic                     byte_valid;
   logic                     byte_ack;
   logic                     go;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdy_sync <= 2'b00;
      else        rdy_sync <= {rdy_sync[0], rx_ready};
   end

   // MCU handshake is only looked at between words.
   assign go = rdy_sync[1] && !fifo_empty;

   // Byte 0 goes straight from the FIFO output in LATCH; later bytes are
   // handed over in the serialiser's final stop cycle, so word_sr[7:0]
   // already holds the next byte at that point.
   always_comb begin
      byte_valid = 1'b0;
      byte_in    = word_sr[7:0];
      if (state == LATCH) begin
         byte_valid = 1'b1;
         byte_in    = fifo_dout[7:0];
      end else if ((state == DATA) && byte_ack && (byte_idx != LAST_BYTE)) begin
         byte_valid = 1'b1;
      end
   end

   // The line-level START/DATA/STOP phases live in the serialiser; the top
   // sits in DATA for the whole byte train of a word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         fifo_rd_en  <= 1'b0;
         tx_ready    <= 1'b0;
         tx_done_sig <= 1'b0;
         word_cnt    <= '0;
         byte_idx    <= '0;
         word_sr     <= '0;
      end else begin
         fifo_rd_en  <= 1'b0;
         tx_done_sig <= 1'b0;
         case (state)
            IDLE: if (!fifo_empty) begin
               state    <= WAIT_RDY;
               tx_ready <= 1'b1;
            end
            WAIT_RDY: if (go) begin
               state      <= FETCH;
               fifo_rd_en <= 1'b1;
            end
            FETCH: state <= LATCH;
            LATCH: begin
               word_sr  <= fifo_dout >> BITS_PER_BYTE;
               byte_idx <= '0;
               state    <= DATA;
            end
            DATA: if (byte_ack) begin
               if (byte_idx == LAST_BYTE) begin
                  state <= NEXT;
                  if (word_cnt == LAST_WORD) begin
                     word_cnt    <= '0;
                     tx_done_sig <= 1'b1;
                  end else begin
                     word_cnt <= word_cnt + WCW'(1);
                  end
               end else begin
                  byte_idx <= byte_idx + BIW'(1);
                  word_sr  <= word_sr >> BITS_PER_BYTE;
               end
            end
            // NEXT folds in the WAIT_RDY test so back-to-back words cost only
            // FETCH + LATCH + NEXT on top of the serial bits.
            NEXT: begin
               if (tx_done_sig) begin
                  state    <= IDLE;
                  tx_ready <= 1'b0;
               end else if (go) begin
                  state      <= FETCH;
                  fifo_rd_en <= 1'b1;
               end else begin
                  state <= WAIT_RDY;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte_tx (
      .clk        (clk),
      .rst_n      (rst_n),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ack   (byte_ack),
      .txd        (uart_txd)
   );

endmodule

// File: tb/tb_fft_uart_tx.sv
`timescale 1ns/1ps
module tb_fft_uart_tx;

   localparam int CPB    = 4;
   localparam int FL     = 4;
   localparam int DW     = 32;
   localparam int WCW    = $clog2(FL + 1);
   localparam int WORD_T = 4 * 10 * CPB + 3;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           fifo_empty = 1'b1;
   logic [DW-1:0]  fifo_dout = '0;
   logic           rx_ready = 1'b0;
   logic           fifo_rd_en, tx_ready, uart_txd, tx_done_sig;
   logic [WCW-1:0] word_cnt;

   always #5 clk = ~clk;

   fft_uart_tx #(.CLKS_PER_BIT(CPB), .FRAME_LEN(FL), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
      .fifo_rd_en(fifo_rd_en), .rx_ready(rx_ready), .tx_ready(tx_ready),
      .uart_txd(uart_txd), .tx_done_sig(tx_done_sig), .word_cnt(word_cnt)
   );

   int tests = 0, fails = 0;
   longint cyc = 0;
   longint first_fetch = -1;
   int rd_cnt = 0, rd_viol = 0, done_cnt = 0, frame_err = 0;
   logic [DW-1:0] fifo_q[$];
   logic [7:0]    exp_bytes[$];
   logic [7:0]    rx_bytes[$];

   typedef struct { logic [31:0] word; logic [31:0] exp_seq; } vec_t;
   vec_t vt[5];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      tests++; fails++;
      $display("FAIL %s: timed out", name);
   endtask

   // Standard-mode FIFO: data appears the cycle after the read strobe.
   always @(posedge clk) begin
      cyc++;
      if (fifo_rd_en && fifo_q.size() > 0) begin
         fifo_dout  <= fifo_q.pop_front();
         fifo_empty <= (fifo_q.size() == 0);
      end
   end

   task automatic push_word(input logic [DW-1:0] w);
      fifo_q.push_back(w);
      fifo_empty = 1'b0;
      for (int i = 0; i < DW / 8; i++) exp_bytes.push_back(8'((w >> (8 * i)) & 32'hFF));
   endtask

   always @(negedge clk) if (rst_n) begin
      if (fifo_rd_en) begin
         rd_cnt++;
         if (first_fetch < 0) first_fetch = cyc;
         if (fifo_empty) rd_viol++;
      end
      if (tx_done_sig) done_cnt++;
   end

   // Line decoder: from the first low sample, 10 bit cells of CPB samples each;
   // every cell must be flat, the first low and the last high.
   int mon_n = 0;
   logic [10*CPB-1:0] mon_bits;
   logic mon_ok;
   logic [7:0] mon_b;
   always @(negedge clk) begin
      if (!rst_n) mon_n = 0;
      else if (mon_n == 0) begin
         if (uart_txd === 1'b0) begin mon_bits = '0; mon_n = 1; end
      end else begin
         mon_bits[mon_n] = uart_txd;
         mon_n++;
         if (mon_n == 10 * CPB) begin
            mon_ok = 1'b1;
            for (int g = 0; g < 10; g++)
               for (int k = 1; k < CPB; k++)
                  if (mon_bits[g*CPB+k] !== mon_bits[g*CPB]) mon_ok = 1'b0;
            if (mon_bits[9*CPB] !== 1'b1) mon_ok = 1'b0;
            for (int i = 0; i < 8; i++) mon_b[i] = mon_bits[(i+1)*CPB];
            rx_bytes.push_back(mon_b);
            if (!mon_ok) frame_err++;
            mon_n = 0;
         end
      end
   end

   // Called at a negedge. The FIFO is external and keeps its contents, so the
   // expected stream restarts from whatever words remain in it.
   task automatic apply_reset(input string name);
      rst_n = 1'b0;
      #1;
      check({name, " txd"}, uart_txd, 1'b1);
      check({name, " tx_ready"}, tx_ready, 1'b0);
      check({name, " word_cnt"}, word_cnt, 0);
      check({name, " rd_en"}, fifo_rd_en, 1'b0);
      check({name, " done"}, tx_done_sig, 1'b0);
      repeat (3) @(negedge clk);
      rx_bytes.delete(); exp_bytes.delete();
      foreach (fifo_q[i])
         for (int b = 0; b < DW / 8; b++) exp_bytes.push_back(8'((fifo_q[i] >> (8 * b)) & 32'hFF));
      rd_cnt = 0; done_cnt = 0; frame_err = 0; first_fetch = -1;
      rst_n = 1'b1;
   endtask

   task automatic wait_wc(input int target, input int budget, input string name);
      int n = 0;
      while (word_cnt !== WCW'(target) && n < budget) begin @(negedge clk); n++; end
      if (n >= budget) timeout(name);
   endtask

   task automatic wait_done(input int budget, input string name);
      int n = 0;
      while (tx_done_sig !== 1'b1 && n < budget) begin @(negedge clk); n++; end
      if (n >= budget) timeout(name);
   endtask

   task automatic wait_rx(input int cnt, input int budget, input string name);
      int n = 0;
      while (rx_bytes.size() < cnt && n < budget) begin @(negedge clk); n++; end
      if (n >= budget) timeout(name);
   endtask

   task automatic idle_watch(input int ncyc, output int viol);
      viol = 0;
      repeat (ncyc) begin
         @(negedge clk);
         if (uart_txd !== 1'b1 || fifo_rd_en !== 1'b0) viol++;
      end
   endtask

   task automatic check_bytes(input string name);
      check({name, " byte count"}, rx_bytes.size(), exp_bytes.size());
      for (int i = 0; i < exp_bytes.size() && i < rx_bytes.size(); i++)
         check($sformatf("%s byte%0d", name, i), rx_bytes[i], exp_bytes[i]);
      check({name, " framing"}, frame_err, 0);
   endtask

   initial begin
      int viol, first_low;
      longint dur;
      logic [31:0] got;

      vt[0] = '{32'h12345678, 32'h78563412};
      vt[1] = '{32'h00000000, 32'h00000000};
      vt[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF};
      vt[3] = '{32'hA5A5A5A5, 32'hA5A5A5A5};
      vt[4] = '{32'h00000001, 32'h01000000};

      // Reset state, then a single word.
      @(negedge clk);
      apply_reset("reset");
      rx_ready = 1'b1;
      repeat (4) @(negedge clk);
      push_word(vt[0].word);
      wait_wc(1, 400, "single wc");
      repeat (5) @(negedge clk);
      check("single byte count", rx_bytes.size(), 4);
      if (rx_bytes.size() == 4) begin
         got = {rx_bytes[0], rx_bytes[1], rx_bytes[2], rx_bytes[3]};
         check("single bytes", got, vt[0].exp_seq);
      end
      check("single framing", frame_err, 0);
      check("single rd pulses", rd_cnt, 1);
      check("single no done", done_cnt, 0);
      check("single word_cnt", word_cnt, 1);
      check("single tx_ready", tx_ready, 1'b1);

      // Full frame from the vector table.
      @(negedge clk);
      apply_reset("frame reset");
      repeat (4) @(negedge clk);
      for (int i = 1; i <= 4; i++) push_word(vt[i].word);
      wait_done(1000, "frame done");
      // The done cycle is the last of the 4*WORD_T cycles starting at FETCH.
      dur = cyc - first_fetch;
      check("frame duration", dur, 4 * WORD_T - 1);
      check("frame word_cnt at done", word_cnt, 0);
      check("frame tx_ready at done", tx_ready, 1'b1);
      @(negedge clk);
      check("frame tx_ready after", tx_ready, 1'b0);
      check("frame done width", tx_done_sig, 1'b0);
      repeat (20) @(negedge clk);
      check("frame done count", done_cnt, 1);
      check("frame rd pulses", rd_cnt, 4);
      check("frame byte count", rx_bytes.size(), 16);
      for (int i = 1; i <= 4; i++) if (rx_bytes.size() == 16) begin
         got = {rx_bytes[4*i-4], rx_bytes[4*i-3], rx_bytes[4*i-2], rx_bytes[4*i-1]};
         check($sformatf("frame word%0d", i), got, vt[i].exp_seq);
      end
      check("frame framing", frame_err, 0);

      // Handshake stall, then release.
      rx_ready = 1'b0;
      @(negedge clk);
      apply_reset("stall reset");
      push_word($urandom);
      idle_watch(1000, viol);
      check("stall line/rd_en", viol, 0);
      check("stall tx_ready", tx_ready, 1'b1);
      rx_ready = 1'b1;
      first_low = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (first_low == 0 && uart_txd === 1'b0) first_low = i;
      end
      check("stall start latency", first_low, 5);
      wait_wc(1, 400, "stall wc");
      repeat (3) @(negedge clk);
      check_bytes("stall");

      // rx_ready dropped during byte 1.
      @(negedge clk);
      apply_reset("drop reset");
      push_word($urandom); push_word($urandom);
      wait_rx(1, 400, "drop byte0");
      rx_ready = 1'b0;
      wait_wc(1, 400, "drop wc1");
      idle_watch(300, viol);
      check("drop hold line/rd_en", viol, 0);
      check("drop hold word_cnt", word_cnt, 1);
      check("drop first word bytes", rx_bytes.size(), 4);
      rx_ready = 1'b1;
      wait_wc(2, 400, "drop wc2");
      repeat (3) @(negedge clk);
      check_bytes("drop");

      // FIFO underrun after word 2.
      @(negedge clk);
      apply_reset("underrun reset");
      push_word($urandom); push_word($urandom);
      wait_wc(2, 800, "underrun wc2");
      idle_watch(300, viol);
      check("underrun line/rd_en", viol, 0);
      check("underrun word_cnt", word_cnt, 2);
      check("underrun tx_ready", tx_ready, 1'b1);
      check("underrun no done", done_cnt, 0);
      push_word($urandom); push_word($urandom);
      wait_done(800, "underrun done");
      repeat (3) @(negedge clk);
      check("underrun done count", done_cnt, 1);
      check_bytes("underrun");

      // Reset during data bit 3 of byte 0; the popped word is lost.
      @(negedge clk);
      apply_reset("midbyte pre");
      push_word($urandom); push_word($urandom);
      begin
         int n = 0;
         while (fifo_rd_en !== 1'b1 && n < 100) begin @(negedge clk); n++; end
         if (n >= 100) timeout("midbyte fetch");
      end
      repeat (19) @(negedge clk);
      apply_reset("midbyte");
      wait_wc(1, 400, "midbyte wc");
      repeat (3) @(negedge clk);
      check("midbyte tx_ready", tx_ready, 1'b1);
      check_bytes("midbyte");

      // Two back-to-back frames of random data.
      @(negedge clk);
      apply_reset("b2b reset");
      for (int i = 0; i < 2 * FL; i++) push_word($urandom);
      wait_done(1000, "b2b done1");
      @(negedge clk);
      check("b2b idle gap", tx_ready, 1'b0);
      @(negedge clk);
      check("b2b rearm", tx_ready, 1'b1);
      wait_done(1000, "b2b done2");
      repeat (3) @(negedge clk);
      check("b2b done count", done_cnt, 2);
      check_bytes("b2b");
      check("rd_en while empty", rd_viol, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fft_uart_tx.md
Name: fft_uart_tx

Overview:
- Drains FFT result words from the output FIFO and serialises them over a UART 8N1 line to the MCU. Fed by the FFT-output FIFO; drives the board UART TXD pin.
- Runs the MCU handshake: the block raises tx_ready and the MCU answers with rx_ready.
- Sends one frame of FRAME_LEN 32-bit words, then pulses tx_done_sig.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200).
- FRAME_LEN, 1024, words per frame (FFT length).
- DATA_W, 32, FIFO word width; must be a multiple of 8.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_dout  in  DATA_W  FIFO read data; standard mode, valid 1 cycle after fifo_rd_en.
- fifo_rd_en  out  1  FIFO read strobe, one-cycle pulse.
- rx_ready  in  1  MCU ready to receive; asynchronous, 2-flop synchronised inside.
- tx_ready  out  1  frame pending or in progress.
- uart_txd  out  1  serial line, idle high.
- tx_done_sig  out  1  one-cycle pulse after the last stop bit of a frame.
- word_cnt  out  clog2(FRAME_LEN+1)  words fully sent in the current frame.

Behaviour:
- Reset values (async on rst_n low): uart_txd=1, fifo_rd_en=0, tx_ready=0, tx_done_sig=0, word_cnt=0, FSM=IDLE.
- Reset mid-byte takes effect immediately: line returns high, the partial word is discarded, and the FIFO is not rewound.
- States: IDLE, WAIT_RDY, FETCH, LATCH, START, DATA, STOP, NEXT.
- IDLE: on !fifo_empty go to WAIT_RDY with tx_ready=1.
- tx_ready stays 1 from WAIT_RDY through the tx_done_sig cycle, then 0 in IDLE.
- WAIT_RDY: when synced rx_ready=1 AND !fifo_empty, go to FETCH.
  - Condition false: hold; line stays high indefinitely.
- FETCH: fifo_rd_en=1 for exactly one cycle, then LATCH.
- LATCH: capture fifo_dout into the shift register, byte_idx=0, go to START.
- START: uart_txd=0 for CLKS_PER_BIT cycles, go to DATA.
- DATA: 8 bits of the current byte, LSB first, each CLKS_PER_BIT cycles, then STOP.
- STOP: uart_txd=1 for CLKS_PER_BIT cycles.
  - If byte_idx < DATA_W/8-1: byte_idx++, go to START. Bytes go out little-endian, byte 0 = bits[7:0].
  - Otherwise go to NEXT.
- NEXT (one cycle): word_cnt++.
  - If word_cnt+1 == FRAME_LEN: tx_done_sig=1, word_cnt←0, go to IDLE.
  - Otherwise go to WAIT_RDY.
- rx_ready is sampled only at word boundaries (WAIT_RDY). Deassertion mid-word has no effect and the word completes.
- FIFO empty mid-frame: hold in WAIT_RDY with the line high. The frame resumes when data arrives; no timeout.
- Bit timer: a counter 0..CLKS_PER_BIT-1 reloads each bit. Bit edges are exact, with no drift accumulation.
- Word timing: 4 bytes × 10 bits × CLKS_PER_BIT, plus a 3-cycle overhead (FETCH, LATCH, NEXT) while rx_ready stays high and the FIFO stays non-empty.
- fifo_rd_en is never asserted while fifo_empty=1, and never more than once per word.
- Consecutive frames: the IDLE→WAIT_RDY transition happens the cycle after tx_done_sig when the FIFO is still non-empty.

Decomposition:
- Shared package fft_uart_pkg holds:
  - the FSM state enum;
  - the UART constants: START_BIT=0, STOP_BIT=1, BITS_PER_BYTE=8;
  - a clog2 function.
- One natural sub-module: uart_byte_tx. It contains the bit timer and the START/DATA/STOP sequencing.
  - Interface: byte_in, byte_valid, byte_ack (pulse at end of stop bit), txd.
  - The top-level FSM then handles only word, byte and frame sequencing.

Test Plan:
- Parameters for all tests: CLKS_PER_BIT=4, FRAME_LEN=4.
- Single word: FIFO holds 0x12345678, rx_ready=1.
  - Bytes 0x78, 0x56, 0x34, 0x12 appear on uart_txd, LSB first, each bit exactly 4 cycles.
  - One fifo_rd_en pulse; word_cnt=1; no tx_done_sig.
- Full frame: 4 words 0x0, 0xFFFFFFFF, 0xA5A5A5A5, 0x1.
  - Decoded by a bench UART monitor in that order.
  - tx_done_sig pulses once, 1 cycle after the final stop bit; word_cnt returns to 0; tx_ready falls next cycle.
  - Total duration 4×163 cycles after the first FETCH.
- Handshake stall: rx_ready=0 with FIFO non-empty.
  - tx_ready=1, uart_txd stays 1, no fifo_rd_en for 1000 cycles.
  - Raising rx_ready gives a start bit 5 cycles later (2 sync + WAIT_RDY + FETCH + LATCH).
- Mid-word rx_ready drop: deassert during byte 1.
  - The word completes all 4 bytes; the next word is held in WAIT_RDY until rx_ready=1.
- FIFO underrun: empty after word 2 of 4.
  - Line idles high and word_cnt=2 holds; refilling resumes words 3-4, then tx_done_sig.
- Reset mid-byte: rst_n low during DATA bit 3.
  - uart_txd=1, tx_ready=0, word_cnt=0 immediately.
  - After release with the FIFO non-empty, a fresh frame starts.
